// File: rtl/seq_task_dispatcher.sv
// Command-driven sequencer granting exclusive run enable to NUM_TASKS tasks in index order.
// Supports single/continuous passes, abort, per-task watchdog, one-cycle handover gap, pass counter.
module seq_task_dispatcher #(
  parameter int          NUM_TASKS  = 2,
  parameter logic [7:0]  CMD_SINGLE = 8'd98,
  parameter logic [7:0]  CMD_CONT   = 8'd99,
  parameter logic [7:0]  CMD_ABORT  = 8'd115,
  parameter logic [23:0] TIMEOUT    = 24'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_data_fresh,
  input  logic [NUM_TASKS-1:0] done,
  output logic [NUM_TASKS-1:0] grant,
  output logic                 busy,
  output logic                 cont_mode,
  output logic                 pass_done,
  output logic [15:0]          pass_count,
  output logic                 timeout_err
);

  localparam int IDX_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TASKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_TASKS-1:0]  grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic                  cont_q, cont_d;
  logic                  pass_done_q, pass_done_d;
  logic [15:0]           pass_count_q, pass_count_d;
  logic                  terr_q, terr_d;
  logic [23:0]           wdog_q, wdog_d;

  logic cmd_single, cmd_cont, cmd_abort;
  logic task_done, wdog_expired;

  assign cmd_single   = rx_data_fresh && (rx_data == CMD_SINGLE);
  assign cmd_cont     = rx_data_fresh && (rx_data == CMD_CONT);
  assign cmd_abort    = rx_data_fresh && (rx_data == CMD_ABORT);
  assign task_done    = done[idx_q];
  assign wdog_expired = (TIMEOUT != 24'd0) && (wdog_q == (TIMEOUT - 24'd1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cont_d       = cont_q;
    pass_done_d  = 1'b0;
    pass_count_d = pass_count_q;
    terr_d       = terr_q;
    wdog_d       = 24'd0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_single || cmd_cont) begin
          state_d = ST_RUN;
          idx_d   = '0;
          cont_d  = cmd_cont;
          terr_d  = 1'b0;
        end
      end

      ST_RUN: begin
        // Mode commands land first so a same-cycle last done sees the updated mode.
        if (cmd_cont)   cont_d = 1'b1;
        if (cmd_single) cont_d = 1'b0;

        if (cmd_abort) begin
          state_d = ST_IDLE;
          cont_d  = 1'b0;
        end else if (task_done) begin
          if (idx_q != LAST_IDX) begin
            state_d = ST_GAP;
            idx_d   = idx_q + 1'b1;
          end else begin
            pass_done_d  = 1'b1;
            pass_count_d = pass_count_q + 16'd1;
            idx_d        = '0;
            state_d      = cont_d ? ST_GAP : ST_IDLE;
          end
        end else if (wdog_expired) begin
          state_d = ST_IDLE;
          terr_d  = 1'b1;
          cont_d  = 1'b0;
        end else begin
          wdog_d = wdog_q + 24'd1;
        end
      end

      ST_GAP: begin
        if (cmd_cont)   cont_d = 1'b1;
        if (cmd_single) cont_d = 1'b0;

        if (cmd_abort) begin
          state_d = ST_IDLE;
          cont_d  = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cont_d  = 1'b0;
      end
    endcase

    grant_d = '0;
    if (state_d == ST_RUN) grant_d[idx_d] = 1'b1;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      cont_q       <= 1'b0;
      pass_done_q  <= 1'b0;
      pass_count_q <= 16'd0;
      terr_q       <= 1'b0;
      wdog_q       <= 24'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      cont_q       <= cont_d;
      pass_done_q  <= pass_done_d;
      pass_count_q <= pass_count_d;
      terr_q       <= terr_d;
      wdog_q       <= wdog_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign cont_mode   = cont_q;
  assign pass_done   = pass_done_q;
  assign pass_count  = pass_count_q;
  assign timeout_err = terr_q;

endmodule
